// File: rtl/master_rx_ltssm_pkg.sv
// Shared definitions for the receive-side LTSSM helper: substate encoding,
// ordered-set constants, per-substate success thresholds and timer codes.
// Pure definitions, no logic or timing.
package master_rx_ltssm_pkg;

   typedef enum logic [3:0] {
      DETECT_QUIET   = 4'd0,
      DETECT_ACTIVE  = 4'd1,
      POLLING_ACTIVE = 4'd2,
      POLLING_CONFIG = 4'd3,
      CFG_LW_START   = 4'd4,
      CFG_LW_ACCEPT  = 4'd5,
      CFG_LN_WAIT    = 4'd6,
      CFG_LN_ACCEPT  = 4'd7,
      CFG_COMPLETE   = 4'd8,
      CFG_IDLE       = 4'd9
   } substate_e;

   // Exit decision: still evaluating, or decided and holding until substate moves
   typedef enum logic {
      EX_RUN  = 1'b0,
      EX_DONE = 1'b1
   } exit_state_e;

   localparam logic [7:0] PAD    = 8'hF7;
   localparam logic [7:0] TS1_ID = 8'h2A;
   localparam logic [7:0] TS2_ID = 8'h25;

   localparam logic [3:0] THR_LONG  = 4'd8;
   localparam logic [3:0] THR_SHORT = 4'd2;

   localparam logic [5:0] TMR_DETECT_QUIET = 6'd12;
   localparam logic [5:0] TMR_POLL_ACTIVE  = 6'd24;
   localparam logic [5:0] TMR_POLL_CONFIG  = 6'd48;
   localparam logic [5:0] TMR_CFG_LW_START = 6'd24;
   localparam logic [5:0] TMR_DEFAULT      = 6'd2;

   // Consecutive matching ordered sets needed before a lane counts as trained
   function automatic logic [3:0] threshold(input substate_e s);
      case (s)
         POLLING_ACTIVE, POLLING_CONFIG, CFG_COMPLETE, CFG_IDLE: return THR_LONG;
         default:                                                return THR_SHORT;
      endcase
   endfunction

   // Timeout in milliseconds handed to the external substate timer
   function automatic logic [5:0] timer_ms(input substate_e s);
      case (s)
         DETECT_QUIET:   return TMR_DETECT_QUIET;
         POLLING_ACTIVE: return TMR_POLL_ACTIVE;
         POLLING_CONFIG: return TMR_POLL_CONFIG;
         CFG_LW_START:   return TMR_CFG_LW_START;
         default:        return TMR_DEFAULT;
      endcase
   endfunction

endpackage

// File: rtl/master_rx_ltssm_if.sv
// Ordered-set receive bus from the block aligners plus the exit decision back to the LTSSM.
// No latency of its own; carries one 128-bit word per lane with a shared valid.
// No backpressure: the aligners stream, valid simply qualifies each cycle.
interface master_rx_ltssm_if #(
   parameter int LANES = 16
) ();
   logic [128*LANES-1:0] orderedSets;
   logic                 valid;
   logic                 finish;
   logic [3:0]           exitTo;

   modport master (
      output orderedSets, valid,
      input  finish, exitTo
   );

   modport slave (
      input  orderedSets, valid,
      output finish, exitTo
   );
endinterface

// File: rtl/master_rx_ltssm_os_checker.sv
// Per-lane ordered-set matcher with a saturating count of consecutive matches.
// Match is combinational; the count updates on the edge where valid is sampled.
// No backpressure: valid low holds the count, clr (substate change) wins over valid.
module os_checker
   import master_rx_ltssm_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  substate_e    substate,
   input  logic [7:0]   link_number,
   input  logic [3:0]   lane_idx,
   input  logic [127:0] os_dat,
   input  logic         os_vld,
   input  logic         clr,
   output logic         match,
   output logic [3:0]   cnt
);

   logic       is_ts1, is_ts2, is_zero;
   logic       link_pad, lane_pad, link_ok, lane_ok;
   logic [3:0] cnt_d, cnt_q;

   // Decode the TS identifier and link/lane fields and apply the substate's rule
   always_comb begin
      is_ts1 = 1'b1;
      is_ts2 = 1'b1;
      for (int k = 5; k < 12; k++) begin
         if (os_dat[8*k +: 8] != TS1_ID) is_ts1 = 1'b0;
         if (os_dat[8*k +: 8] != TS2_ID) is_ts2 = 1'b0;
      end
      is_zero  = (os_dat == '0);
      link_pad = (os_dat[15:8]  == PAD);
      lane_pad = (os_dat[23:16] == PAD);
      link_ok  = (os_dat[15:8]  == link_number);
      lane_ok  = (os_dat[23:16] == {4'd0, lane_idx});
      match    = 1'b0;
      case (substate)
         POLLING_ACTIVE:              match = (is_ts1 || is_ts2) && link_pad && lane_pad;
         POLLING_CONFIG:              match = is_ts2 && link_pad && lane_pad;
         CFG_LW_START, CFG_LW_ACCEPT: match = is_ts1 && link_ok && lane_pad;
         CFG_LN_WAIT, CFG_LN_ACCEPT:  match = is_ts1 && link_ok && lane_ok;
         CFG_COMPLETE:                match = is_ts2 && link_ok && lane_ok;
         CFG_IDLE:                    match = is_zero;
         default:                     match = 1'b0;
      endcase
   end

   // Consecutive-match count: saturate at 15 so long runs never wrap below threshold
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = 4'd0;
      end else if (os_vld) begin
         if (!match)              cnt_d = 4'd0;
         else if (cnt_q != 4'hF)  cnt_d = cnt_q + 4'd1;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= 4'd0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/master_rx_ltssm.sv
// Receive-side LTSSM exit logic: per-lane OS checks, exit decision, timer control, rate capture.
// Counts update on the valid edge; finish/exitTo register one edge after the deciding count.
// No backpressure: finish/exitTo hold until the controller changes substate.
module master_rx_ltssm
   import master_rx_ltssm_pkg::*;
#(
   parameter int LANES = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   master_rx_ltssm_if.slave        rx,
   input  logic [4:0]              numberOfDetectedLanes,
   input  logic [3:0]              substate,
   input  logic [7:0]              linkNumber,
   input  logic                    forceDetect,
   input  logic                    rxElectricalIdle,
   input  logic                    timeOut,
   output logic                    disableDescrambler,
   output logic [5:0]              setTimer,
   output logic                    enableTimer,
   output logic                    resetTimer,
   output logic                    writeRateId,
   output logic                    writeUpconfig,
   output logic [7:0]              rateId,
   output logic                    upconfigureCapability
);

   substate_e   sub_cur;
   substate_e   substate_d, substate_q;
   logic        sub_chg;
   exit_state_e state_d, state_q;
   logic [3:0]  exit_to_d, exit_to_q;
   logic        reset_timer_d, reset_timer_q;
   logic        wr_strobe_d, wr_strobe_q;
   logic [7:0]  rate_id_d, rate_id_q;
   logic        upcfg_d, upcfg_q;
   logic        lanes_ok, success;
   logic [3:0]  thr;

   logic [LANES-1:0] lane_match;
   logic [3:0]       lane_cnt [LANES];
   logic             unused_lane_match;

   assign sub_cur = substate_e'(substate);
   assign sub_chg = (sub_cur != substate_q);

   // Only lane 0 feeds the capture path; the other lanes' match flags are not needed
   assign unused_lane_match = ^lane_match;

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         os_checker u_chk (
            .clk         (clk),
            .reset       (reset),
            .substate    (sub_cur),
            .link_number (linkNumber),
            .lane_idx    (4'(i)),
            .os_dat      (rx.orderedSets[128*i +: 128]),
            .os_vld      (rx.valid),
            .clr         (sub_chg),
            .match       (lane_match[i]),
            .cnt         (lane_cnt[i])
         );
      end
   endgenerate

   // Success: detect substates by their own rule, the rest by all active lanes at threshold
   always_comb begin
      thr      = threshold(sub_cur);
      lanes_ok = 1'b1;
      for (int i = 0; i < LANES; i++) begin
         if ((i < int'(numberOfDetectedLanes)) && (lane_cnt[i] < thr)) lanes_ok = 1'b0;
      end
      success = 1'b0;
      case (sub_cur)
         DETECT_QUIET:  success = !rxElectricalIdle;
         DETECT_ACTIVE: success = 1'b1;
         POLLING_ACTIVE, POLLING_CONFIG, CFG_LW_START, CFG_LW_ACCEPT,
         CFG_LN_WAIT, CFG_LN_ACCEPT, CFG_COMPLETE, CFG_IDLE:
                        success = lanes_ok;
         default:       success = 1'b0;
      endcase
   end

   // Exit FSM: force beats timeout beats success; the decision sticks until substate moves
   always_comb begin
      state_d       = state_q;
      exit_to_d     = exit_to_q;
      wr_strobe_d   = 1'b0;
      reset_timer_d = sub_chg;
      substate_d    = sub_cur;
      if (sub_chg) begin
         state_d   = EX_RUN;
         exit_to_d = DETECT_QUIET;
      end else if (state_q == EX_RUN) begin
         if (forceDetect) begin
            state_d   = EX_DONE;
            exit_to_d = DETECT_QUIET;
         end else if (timeOut) begin
            state_d   = EX_DONE;
            exit_to_d = (sub_cur == DETECT_QUIET) ? DETECT_ACTIVE : DETECT_QUIET;
         end else if (success) begin
            state_d     = EX_DONE;
            exit_to_d   = (sub_cur == CFG_IDLE) ? CFG_IDLE : (substate + 4'd1);
            wr_strobe_d = (sub_cur == CFG_COMPLETE);
         end
      end
   end

   // Lane 0 rate/upconfigure capture from every matching TS2 seen in cfgComplete
   always_comb begin
      rate_id_d = rate_id_q;
      upcfg_d   = upcfg_q;
      if (!sub_chg && rx.valid && lane_match[0] && (sub_cur == CFG_COMPLETE)) begin
         rate_id_d = rx.orderedSets[39:32];
         upcfg_d   = rx.orderedSets[38];
      end
   end

   // State registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= EX_RUN;
         exit_to_q     <= 4'd0;
         substate_q    <= DETECT_QUIET;
         reset_timer_q <= 1'b0;
         wr_strobe_q   <= 1'b0;
         rate_id_q     <= 8'd0;
         upcfg_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         exit_to_q     <= exit_to_d;
         substate_q    <= substate_d;
         reset_timer_q <= reset_timer_d;
         wr_strobe_q   <= wr_strobe_d;
         rate_id_q     <= rate_id_d;
         upcfg_q       <= upcfg_d;
      end
   end

   assign rx.finish             = (state_q == EX_DONE);
   assign rx.exitTo             = exit_to_q;
   assign enableTimer           = (state_q == EX_RUN);
   assign resetTimer            = reset_timer_q;
   assign setTimer              = timer_ms(sub_cur);
   assign disableDescrambler    = (substate_q != CFG_IDLE);
   assign writeRateId           = wr_strobe_q;
   assign writeUpconfig         = wr_strobe_q;
   assign rateId                = rate_id_q;
   assign upconfigureCapability = upcfg_q;

endmodule

// File: tb/tb_master_rx_ltssm.sv
// Self-checking bench: directed scenarios plus randomized substates, scored against a
// run-length reference model; expected exits are queued and popped when finish rises.
// Inputs are driven 1 time unit after the rising edge, outputs sampled then or on the falling edge.
module tb_master_rx_ltssm;
   localparam int NL = 4;

   logic clk = 1'b0;
   logic reset;
   logic [4:0] n_det;
   logic [3:0] sub;
   logic [7:0] link;
   logic force_d, tout, eidle, vld;
   logic [127:0] os_arr [NL];
   logic dd, en_t, rst_t, wr_r, wr_u, upc;
   logic [5:0] st;
   logic [7:0] rate;

   typedef struct {
      int         edge_no;
      logic [3:0] exit_to;
      logic [7:0] rate;
      bit         upc;
   } exp_t;
   exp_t sb[$];

   int edge_cnt = 0;
   int n_chk = 0;
   int n_fail = 0;

   // reference model state
   int         m_prev;
   int         m_run [NL];
   bit         m_fin;
   logic [7:0] m_rate;
   bit         m_upc;

   master_rx_ltssm_if #(.LANES(NL)) rx_if ();

   master_rx_ltssm #(.LANES(NL)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .rx                    (rx_if),
      .numberOfDetectedLanes (n_det),
      .substate              (sub),
      .linkNumber            (link),
      .forceDetect           (force_d),
      .rxElectricalIdle      (eidle),
      .timeOut               (tout),
      .disableDescrambler    (dd),
      .setTimer              (st),
      .enableTimer           (en_t),
      .resetTimer            (rst_t),
      .writeRateId           (wr_r),
      .writeUpconfig         (wr_u),
      .rateId                (rate),
      .upconfigureCapability (upc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded, required end before %0t", $time);
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, edge_cnt);
      end
   endtask

   function automatic bit all_id(logic [127:0] os, logic [7:0] id);
      for (int k = 5; k < 12; k++) if (os[8*k +: 8] != id) return 1'b0;
      return 1'b1;
   endfunction

   // Ordered-set acceptance rules, one line per substate
   function automatic bit os_ok(int s, logic [127:0] os, int lane, logic [7:0] lk);
      logic [7:0] l, n;
      l = os[15:8];
      n = os[23:16];
      case (s)
         2:       return (all_id(os, 8'h2A) || all_id(os, 8'h25)) && l == 8'hF7 && n == 8'hF7;
         3:       return all_id(os, 8'h25) && l == 8'hF7 && n == 8'hF7;
         4, 5:    return all_id(os, 8'h2A) && l == lk && n == 8'hF7;
         6, 7:    return all_id(os, 8'h2A) && l == lk && n == 8'(lane);
         8:       return all_id(os, 8'h25) && l == lk && n == 8'(lane);
         9:       return os == '0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int need(int s);
      case (s)
         2, 3, 8, 9: return 8;
         default:    return 2;
      endcase
   endfunction

   function automatic logic [5:0] exp_timer(int s);
      case (s)
         0:       return 6'd12;
         2:       return 6'd24;
         3:       return 6'd48;
         4:       return 6'd24;
         default: return 6'd2;
      endcase
   endfunction

   function automatic logic [127:0] mk(logic [7:0] id, logic [7:0] lk, logic [7:0] ln, logic [7:0] rt);
      logic [127:0] o;
      o = '0;
      for (int k = 5; k < 12; k++) o[8*k +: 8] = id;
      o[7:0]   = 8'hAA;
      o[15:8]  = lk;
      o[23:16] = ln;
      o[31:24] = 8'hAA;
      o[39:32] = rt;
      return o;
   endfunction

   // A well-formed OS for substate s with random don't-care bytes
   function automatic logic [127:0] good_os(int s, int lane, logic [7:0] lk);
      logic [127:0] o;
      logic [7:0]   id;
      if (s == 9) return '0;
      o  = {$urandom, $urandom, $urandom, $urandom};
      id = (s == 3 || s == 8 || (s == 2 && $urandom_range(0, 1) == 1)) ? 8'h25 : 8'h2A;
      for (int k = 5; k < 12; k++) o[8*k +: 8] = id;
      o[15:8]  = (s >= 4) ? lk : 8'hF7;
      o[23:16] = (s >= 6) ? 8'(lane) : 8'hF7;
      return o;
   endfunction

   task automatic model_reset();
      m_prev = 0;
      for (int i = 0; i < NL; i++) m_run[i] = 0;
      m_fin  = 1'b0;
      m_rate = 8'd0;
      m_upc  = 1'b0;
   endtask

   task automatic set_all(input logic [127:0] v);
      for (int i = 0; i < NL; i++) os_arr[i] = v;
   endtask

   // Apply current inputs for one edge, predict the response, check per-cycle outputs
   task automatic step();
      bit   chg, succ, exp_wr;
      exp_t r;
      for (int i = 0; i < NL; i++) rx_if.orderedSets[128*i +: 128] = os_arr[i];
      rx_if.valid = vld;
      chg    = (int'(sub) != m_prev);
      exp_wr = 1'b0;
      if (chg) begin
         for (int i = 0; i < NL; i++) m_run[i] = 0;
         m_fin = 1'b0;
      end else begin
         if (sub == 0)      succ = !eidle;
         else if (sub == 1) succ = 1'b1;
         else begin
            succ = 1'b1;
            for (int i = 0; i < NL; i++)
               if (i < int'(n_det) && m_run[i] < need(int'(sub))) succ = 1'b0;
         end
         if (vld && sub == 8 && os_ok(8, os_arr[0], 0, link)) begin
            m_rate = os_arr[0][39:32];
            m_upc  = os_arr[0][38];
         end
         if (!m_fin && (force_d || tout || succ)) begin
            m_fin     = 1'b1;
            r.exit_to = force_d ? 4'd0 : tout ? ((sub == 0) ? 4'd1 : 4'd0)
                                              : ((sub == 9) ? 4'd9 : sub + 4'd1);
            exp_wr    = !force_d && !tout && sub == 8;
            r.edge_no = edge_cnt + 1;
            r.rate    = m_rate;
            r.upc     = m_upc;
            sb.push_back(r);
         end
         if (vld)
            for (int i = 0; i < NL; i++)
               m_run[i] = os_ok(int'(sub), os_arr[i], i, link) ? ((m_run[i] < 15) ? m_run[i] + 1 : 15) : 0;
      end
      m_prev = int'(sub);
      @(posedge clk);
      #1;
      chk("reset_timer", 32'(rst_t), 32'(chg));
      chk("enable_timer", 32'(en_t), 32'(!m_fin));
      chk("set_timer", 32'(st), 32'(exp_timer(int'(sub))));
      chk("disable_descrambler", 32'(dd), 32'(sub != 4'd9));
      chk("write_strobes", 32'({wr_r, wr_u}), 32'({exp_wr, exp_wr}));
   endtask

   // Monitor: every rising finish must match the oldest predicted exit
   logic fin_prev = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         fin_prev = 1'b0;
      end else begin
         if (rx_if.finish && !fin_prev) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_finish: got exitTo %0d at edge %0d, expected no finish", rx_if.exitTo, edge_cnt);
            end else begin
               exp_t r;
               r = sb.pop_front();
               chk("finish_edge", 32'(edge_cnt), 32'(r.edge_no));
               chk("exit_to", 32'(rx_if.exitTo), 32'(r.exit_to));
               chk("rate_id", 32'(rate), 32'(r.rate));
               chk("upconfigure", 32'(upc), 32'(r.upc));
            end
         end
         fin_prev = rx_if.finish;
      end
   end

   initial begin
      reset = 1'b0; sub = 4'd0; n_det = 5'd2; link = 8'd0;
      force_d = 1'b0; tout = 1'b0; eidle = 1'b1; vld = 1'b0;
      set_all('0);
      rx_if.orderedSets = '0;
      rx_if.valid = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_finish", 32'(rx_if.finish), 32'd0);
      chk("rst_exit_to", 32'(rx_if.exitTo), 32'd0);
      chk("rst_rate_upcfg", 32'({rate, upc}), 32'd0);
      chk("rst_strobes_timer", 32'({wr_r, wr_u, rst_t}), 32'd0);
      chk("rst_descrambler", 32'(dd), 32'd1);
      reset = 1'b1;

      // pollingActive, two lanes of TS2 with PAD link/lane
      sub = 4'd2; n_det = 5'd2; vld = 1'b1;
      set_all(128'h25252525252525AAAAF7F7F7);
      repeat (11) step();

      // pollingConfiguration: run of 3, a broken word, run of 2 -> no exit
      sub = 4'd3; set_all(mk(8'h25, 8'hF7, 8'hF7, 8'hAA));
      repeat (4) step();
      set_all(mk(8'h25, 8'hAA, 8'hAA, 8'hAA));
      step();
      set_all(mk(8'h25, 8'hF7, 8'hF7, 8'hAA));
      repeat (2) step();

      // cfgLinkWidthStart with link 1
      sub = 4'd4; link = 8'd1; set_all(128'h2A2A2A2A2A2A2AAAAAF701F7);
      repeat (5) step();

      // pollingActive: lane 0 runs long alone (must saturate), then lane 1 catches up
      sub = 4'd2; n_det = 5'd2; set_all('0);
      os_arr[0] = mk(8'h2A, 8'hF7, 8'hF7, 8'h00);
      repeat (13) step();
      os_arr[1] = mk(8'h25, 8'hF7, 8'hF7, 8'h00);
      repeat (10) step();

      // cfgLinkWidthAccept: lane 1 never matches; shrinking the lane count lets it exit
      sub = 4'd5; set_all('0);
      os_arr[0] = mk(8'h2A, 8'd1, 8'hF7, 8'h00);
      repeat (6) step();
      n_det = 5'd1;
      repeat (2) step();

      // timeout in pollingActive
      sub = 4'd2; n_det = 5'd2; set_all(mk(8'h2A, 8'hF7, 8'hF7, 8'h00));
      repeat (3) step();
      tout = 1'b1; step(); tout = 1'b0; step();

      // forceDetect on the same edge that success would be decided
      sub = 4'd4; set_all(mk(8'h2A, 8'd1, 8'hF7, 8'h00));
      repeat (3) step();
      force_d = 1'b1; step(); force_d = 1'b0; step();

      // cfgComplete with rate byte 0xC2 on all four lanes
      sub = 4'd8; link = 8'd7; n_det = 5'd4;
      for (int i = 0; i < NL; i++) os_arr[i] = mk(8'h25, 8'd7, 8'(i), 8'hC2);
      repeat (11) step();

      // asynchronous reset while finish and captured rate are set
      #2 reset = 1'b0;
      #1;
      chk("async_rst_finish", 32'({rx_if.finish, rx_if.exitTo}), 32'd0);
      chk("async_rst_rate", 32'({rate, upc}), 32'd0);
      chk("async_rst_descrambler", 32'(dd), 32'd1);
      model_reset();
      @(posedge clk); #1;
      reset = 1'b1;

      // cfgIdle: all-zero words, descrambler enabled
      sub = 4'd9; set_all('0);
      repeat (11) step();

      // detect substates
      sub = 4'd0; eidle = 1'b1; repeat (4) step();
      eidle = 1'b0; repeat (2) step();
      sub = 4'd1; repeat (3) step();
      sub = 4'd0; eidle = 1'b1; repeat (2) step();
      tout = 1'b1; step(); tout = 1'b0; step();

      // randomized substates, lane counts and corruption
      for (int p = 0; p < 40; p++) begin
         int cyc;
         sub   = 4'($urandom_range(0, 9));
         n_det = 5'($urandom_range(1, NL));
         link  = 8'($urandom);
         cyc   = $urandom_range(4, 20);
         for (int c = 0; c < cyc; c++) begin
            vld     = ($urandom_range(0, 7) != 0);
            eidle   = ($urandom_range(0, 1) == 0);
            force_d = ($urandom_range(0, 96) == 0);
            tout    = ($urandom_range(0, 60) == 0);
            for (int i = 0; i < NL; i++) begin
               os_arr[i] = good_os(int'(sub), i, link);
               if ($urandom_range(0, 23) == 0) begin
                  int k;
                  k = $urandom_range(0, 15);
                  os_arr[i][8*k +: 8] = os_arr[i][8*k +: 8] ^ 8'($urandom_range(1, 255));
               end
            end
            step();
         end
      end

      force_d = 1'b0; tout = 1'b0; vld = 1'b0;
      repeat (2) step();
      chk("scoreboard_drain", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/master_rx_ltssm.md
# master_rx_ltssm

Receive-side LTSSM helper for the PCIe link-training path. It checks the incoming ordered sets on every lane against the rules of the current LTSSM substate and counts consecutive matches per lane. When the required count is reached on all detected lanes, or on timeout or forced detect, it signals `finish` with the next substate. It sits between the per-lane block aligners (128-bit ordered-set words) and the main LTSSM controller, which owns `substate`.

## Interface
- `LANES`, default 16: number of lanes instantiated (1–16).
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `numberOfDetectedLanes` input 5: lanes 0..N-1 take part in exit decisions (1..LANES).
- `substate` input 4: current substate: 0 detectQuiet, 1 detectActive, 2 pollingActive, 3 pollingConfiguration, 4 cfgLinkWidthStart, 5 cfgLinkWidthAccept, 6 cfgLanenumWait, 7 cfgLanenumAccept, 8 cfgComplete, 9 cfgIdle.
- `linkNumber` input 8: expected link number in configuration substates.
- `orderedSets` input 128*LANES: lane i occupies bits [128i+127:128i]; byte k = bits [8k+7:8k].
- `valid` input 1: the ordered-set words are valid this cycle (shared by all lanes).
- `forceDetect` input 1: request to return to detect.
- `rxElectricalIdle` input 1: receiver electrical idle.
- `timeOut` input 1: substate timer expired.
- `finish` output 1: exit decided.
- `exitTo` output 4: next substate (same encoding).
- `disableDescrambler` output 1.
- `setTimer` output 6: timeout value in ms for the current substate.
- `enableTimer`, `resetTimer` output 1 each.
- `writeRateId`, `writeUpconfig` output 1 each: capture strobes.
- `rateId` output 8: captured data-rate byte.
- `upconfigureCapability` output 1: captured upconfigure bit.

## Operation
- Ordered-set fields:
  - byte1: link number.
  - byte2: lane number.
  - byte4: rate id; bit 6 is upconfigure capability.
  - bytes 5..11: TS identifier, all 0x2A (TS1) or all 0x25 (TS2).
  - bytes 0, 3, 12..15: don't care.
- PAD is 0xF7.
- Per-lane match rule, by substate:
  - pollingActive: TS1 or TS2, link = PAD, lane = PAD.
  - pollingConfiguration: TS2, link = PAD, lane = PAD.
  - cfgLinkWidthStart / cfgLinkWidthAccept: TS1, link = `linkNumber`, lane = PAD.
  - cfgLanenumWait / cfgLanenumAccept: TS1, link = `linkNumber`, lane = lane index.
  - cfgComplete: TS2, link = `linkNumber`, lane = lane index.
  - cfgIdle: all 16 bytes 0x00.
  - Detect substates: no match.
- Per-lane 4-bit counter, updated on each cycle where `valid` = 1:
  - match: counter + 1, saturating at 15.
  - mismatch: counter cleared to 0.
  - `valid` = 0: counter holds.
- Success thresholds:
  - 8 for pollingActive, pollingConfiguration, cfgComplete and cfgIdle.
  - 2 for the other cfg substates.
  - Success requires every lane below `numberOfDetectedLanes` to be at or above the threshold.
- detectQuiet: success when `rxElectricalIdle` = 0; exits to detectActive.
- detectActive: succeeds on the first cycle; exits to pollingActive.
- Exits: each success moves to the next encoding; cfgIdle exits to 9 (stay/L0 handoff).
- Exit priority:
  1. `forceDetect`: exitTo = detectQuiet.
  2. `timeOut`: exitTo = detectActive from detectQuiet; detectQuiet from any other substate.
  3. Success.
- `finish` and `exitTo` are sticky until `substate` changes or reset.
- Captures on lane 0:
  - `rateId` and `upconfigureCapability` latch from each matching OS in cfgComplete.
  - `writeRateId` and `writeUpconfig` pulse together with the success `finish` of cfgComplete.
- `disableDescrambler` = 1 in every substate except cfgIdle.
- `setTimer` per substate:
  - detectQuiet 12.
  - pollingActive 24.
  - pollingConfiguration 48.
  - cfgLinkWidthStart 24.
  - all others 2.
- `enableTimer` = 1 while `finish` = 0.

## Timing
- Reset values: counters 0, `finish` 0, `exitTo` 0, `rateId` 0, `upconfigureCapability` 0, strobes 0, `resetTimer` 0, `disableDescrambler` 1.
- Substate change: detected by comparing with a registered copy of `substate`. On the edge the change is seen:
  - all counters clear;
  - `finish` clears;
  - `resetTimer` pulses for 1 cycle;
  - `valid` on that edge is ignored.
- Counter latency: the counter updates on the edge where `valid` is sampled.
- `finish` latency: `finish` and `exitTo` register on the following edge. With `valid` held high from the first usable edge, an 8-threshold substate asserts `finish` 9 edges later.
- Asynchronous reset mid-operation returns all registers to their reset values immediately.

## Structure
- Shared package: substate encoding, PAD/TS1/TS2 constants, thresholds, timer codes.
- Sub-module `os_checker`: one per lane, generated. It contains the match logic and the 4-bit counter, and takes the lane index as an input.
- Top level: exit FSM, timer outputs and capture logic.

## Test plan
- Reset low, then high; `substate` = 2; two lanes driven with 0x25252525252525AAAAF7F7F7 and `valid` = 1 for 8 cycles: `finish` = 1, `exitTo` = 3 one edge after the 8th.
- `substate` = 3 with TS2 ×3, then bytes 0..4 all 0xAA, then TS2 ×2: counters go 3 → 0 → 2, `finish` stays 0.
- `substate` = 4, `linkNumber` = 1, 0x2A2A2A2A2A2A2AAAAAF701F7 ×2 on both lanes: `finish` = 1, `exitTo` = 5.
- `numberOfDetectedLanes` = 2, only lane 0 matching: no `finish`. With `numberOfDetectedLanes` = 1: `finish`.
- `timeOut` in pollingActive: `exitTo` = 0. `forceDetect` together with success: `exitTo` = 0.
- cfgComplete with rate byte 0xC2, 8 matching TS2: `rateId` = 0xC2, `upconfigureCapability` = 1, both strobes pulse with `finish`.
